// File: rtl/ps2_rx_pkg.sv
// Shared PS/2 definitions: receiver FSM states, frame length, parity helper.
package ps2_rx_pkg;

  // Receiver FSM states (also used by the keyboard decoder)
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DPS  = 2'd1,
    LOAD = 2'd2
  } ps2_state_t;

  // start + 8 data + parity + stop
  localparam int FRAME_LEN = 11;

  // True when data bits plus the parity bit carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [8:0] data_par);
    return ^data_par;
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// PS/2 pin conditioning: 2-flop synchronizers on clock and data, a
// majority-free all-equal glitch filter on the clock, and a falling-edge
// detector on the filtered clock.
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  input  logic ps2d,
  output logic fall_edge,
  output logic ps2d_s
);

  logic [1:0]            c_sync;
  logic [1:0]            d_sync;
  logic [FILTER_LEN-1:0] filt;
  logic                  f_ps2c;
  logic                  f_ps2c_next;

  // Synchronize both pins and shift the clock into the filter; everything
  // resets to the idle bus level (1) so leaving reset cannot fake an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync <= '1;
      d_sync <= '1;
      filt   <= '1;
      f_ps2c <= 1'b1;
    end else begin
      c_sync <= {c_sync[0], ps2c};
      d_sync <= {d_sync[0], ps2d};
      filt   <= {c_sync[1], filt[FILTER_LEN-1:1]};
      f_ps2c <= f_ps2c_next;
    end
  end

  // Filtered level changes only when the whole window agrees, else holds
  always_comb begin
    f_ps2c_next = f_ps2c;
    if (&filt)
      f_ps2c_next = 1'b1;
    else if (~|filt)
      f_ps2c_next = 1'b0;
  end

  // One-cycle strobe in the cycle the filtered clock register drops 1 -> 0
  assign fall_edge = f_ps2c & ~f_ps2c_next;
  assign ps2d_s    = d_sync[1];

endmodule

// File: rtl/ps2_rx.sv
// PS/2 receiver: frames start/8 data/odd parity/stop bits sampled on the
// filtered falling clock edge, with a timeout that abandons stalled frames.
module ps2_rx
  import ps2_rx_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       rx_en,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       rx_err_tick,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  ps2_state_t           state;
  logic [3:0]           n_reg;
  logic [TW-1:0]        tcnt;
  logic [FRAME_LEN-1:0] b_reg;
  logic                 fall_edge;
  logic                 ps2d_s;
  logic                 frame_ok;

  ps2_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2c     (ps2c),
    .ps2d     (ps2d),
    .fall_edge(fall_edge),
    .ps2d_s   (ps2d_s)
  );

  // b_reg = {stop, parity, d7..d0, start} once all bits have shifted in
  assign frame_ok = odd_parity_ok(b_reg[9:1]) & b_reg[10] & ~b_reg[0];

  // Receiver FSM with registered outputs; ticks default low each cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      n_reg        <= '0;
      tcnt         <= '0;
      b_reg        <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      rx_err_tick  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      rx_err_tick  <= 1'b0;
      case (state)
        IDLE: begin
          // Only a low start bit with receive enabled opens a frame
          if (fall_edge && rx_en && !ps2d_s) begin
            b_reg <= {ps2d_s, b_reg[FRAME_LEN-1:1]};
            n_reg <= 4'(FRAME_LEN - 2);
            tcnt  <= '0;
            state <= DPS;
            busy  <= 1'b1;
          end
        end
        DPS: begin
          if (fall_edge) begin
            b_reg <= {ps2d_s, b_reg[FRAME_LEN-1:1]};
            tcnt  <= '0;
            if (n_reg == 4'd0)
              state <= LOAD;
            else
              n_reg <= n_reg - 4'd1;
          end else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
            rx_err_tick <= 1'b1;
            state       <= IDLE;
            busy        <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        LOAD: begin
          // Edges arriving here are ignored; the frame is judged in one cycle
          if (frame_ok) begin
            dout         <= b_reg[8:1];
            rx_done_tick <= 1'b1;
          end else begin
            rx_err_tick  <= 1'b1;
          end
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 Parameter FILTER_LEN, default 8: number of consecutive equal ps2c samples needed to change the filtered clock level.
REQ-002 Parameter TIMEOUT_CYC, default 10000: number of clk cycles without a filtered falling edge after which a partial frame is abandoned (100 us at 100 MHz).
REQ-003 clk  input  1  system clock, 100 MHz.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ps2c  input  1  PS/2 clock pin, asynchronous.
REQ-006 ps2d  input  1  PS/2 data pin, asynchronous.
REQ-007 rx_en  input  1  receive enable; a new frame starts only while it is high.
REQ-008 dout  output  8  last valid received byte.
REQ-009 rx_done_tick  output  1  one-cycle pulse when dout holds a new valid byte; drives the downstream scan_done_tick.
REQ-010 rx_err_tick  output  1  one-cycle pulse on a parity, stop-bit or timeout error.
REQ-011 busy  output  1  high while a frame is in progress (state not IDLE).

Function
REQ-012 ps2c and ps2d each pass through a 2-flop synchronizer before any use.
REQ-013 Filter: a FILTER_LEN-bit shift register samples synchronized ps2c every clk; the filtered clock goes to 1 when all bits are 1, to 0 when all bits are 0, and otherwise holds.
REQ-014 fall_edge is high for exactly one clk, in the cycle the filtered clock register changes from 1 to 0.
REQ-015 A ps2c pulse or glitch shorter than FILTER_LEN cycles produces no fall_edge.
REQ-016 Frame: start(0), 8 data bits LSB first, odd parity, stop(1); 11 bits total, each sampled from synchronized ps2d on fall_edge.
REQ-017 FSM states: IDLE, DPS (data/parity/stop), LOAD.
REQ-018 IDLE: on fall_edge with rx_en=1 and ps2d=0, capture the start bit, load bit counter with 9, clear the timeout counter, go to DPS.
REQ-019 IDLE: fall_edge with ps2d=1 or rx_en=0 is ignored, and the state stays IDLE.
REQ-020 DPS: each fall_edge shifts ps2d into an 11-bit register MSB-first (right shift) and resets the timeout counter; the counter decrements, and the edge taken at counter 0 moves the FSM to LOAD.
REQ-021 DPS: the timeout counter increments every clk without fall_edge; on reaching TIMEOUT_CYC-1, pulse rx_err_tick and return to IDLE, with dout unchanged.
REQ-022 LOAD (exactly one cycle): if parity is odd across data and parity bit, and stop=1, then dout <= data and rx_done_tick=1; otherwise rx_err_tick=1 and dout is unchanged. In both cases go to IDLE.
REQ-023 Latency: rx_done_tick is asserted 2 clk after the cycle of the 11th fall_edge (one cycle to LOAD, registered output); all outputs are registered.
REQ-024 rx_done_tick and rx_err_tick are never high in the same cycle.
REQ-025 A fall_edge during LOAD is ignored.
REQ-026 Deasserting rx_en mid-frame does not abort the current frame.

Reset
REQ-027 Reset puts the FSM in IDLE and zeroes: bit counter, timeout counter, shift register, dout, rx_done_tick, rx_err_tick, busy.
REQ-028 Reset loads all filter and synchronizer flops with 1 (idle bus level), so release of reset produces no spurious fall_edge.
REQ-029 Reset asserted mid-frame discards the partial frame, and no tick is issued.

Structure
REQ-030 State encodings (IDLE, DPS, LOAD) and the frame-length constant 11 are placed in the shared project package, which the keyboard decoder also uses.
REQ-031 The synchronizer plus filter plus edge detector form one sub-module, ps2_filter (in: clk, reset, ps2c, ps2d; out: fall_edge, ps2d_s), parameterized by FILTER_LEN.

Verification
REQ-032 Send 0x1C, parity 0, stop 1, bit period 60 us -> one rx_done_tick; dout=0x1C; no rx_err_tick.
REQ-033 Send 0xF0 then 0x1C back to back -> two rx_done_tick pulses, carrying 0xF0 then 0x1C in order.
REQ-034 Send 0x1C with parity 1 -> rx_err_tick once, no rx_done_tick, dout keeps its previous value.
REQ-035 3-cycle ps2c low glitch in the middle of a bit -> no extra shift; the frame still decodes 0x1C.
REQ-036 Stop sending after 5 bits -> rx_err_tick exactly TIMEOUT_CYC cycles after the last edge; busy=0; the next full frame 0x29 decodes correctly.
REQ-037 Assert reset after 6 bits, then send 0x1C -> no tick from the partial frame; dout=0x1C after the new frame.
